// File: rtl/freq_divider_multi.sv
// ============================================================================
// Module   : freq_divider_multi
// Brief    : Multi-channel programmable clock divider with square-wave and
//            wrap-pulse outputs; divisors update at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_divider_multi #(
  parameter int               NUM_CH      = 4,
  parameter int               CH_W        = 2,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = 28'd100000000
) (
  input  logic              Pulse,
  input  logic              Reset_n,
  input  logic [NUM_CH-1:0] En,
  input  logic              WrEn,
  input  logic [CH_W-1:0]   WrCh,
  input  logic [WIDTH-1:0]  WrData,
  output logic [NUM_CH-1:0] view,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_two  = WIDTH'(2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] c_ch_id = CH_W'(i);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_div_eff;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_load_val;
    logic             w_wr_hit;
    logic             w_wrap;
    logic             w_load;
    logic             r_view;
    logic             r_tick;
    logic             w_view_nxt;
    logic             w_tick_nxt;

    // Channel ids beyond NUM_CH never match, so such writes fall on the floor.
    assign w_wr_hit   = WrEn && (WrCh == c_ch_id);
    assign w_div_eff  = (r_active < c_two) ? c_two : r_active;
    assign w_half     = w_div_eff >> 1;
    assign w_wrap     = (r_cnt >= (w_div_eff - c_one));
    // A write landing on the load edge must win over the stale shadow.
    assign w_load_val = w_wr_hit ? WrData : r_shadow;

    always_ff @(posedge Pulse or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_active <= DEFAULT_DIV;
        r_shadow <= DEFAULT_DIV;
        r_view   <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_view  <= w_view_nxt;
        r_tick  <= w_tick_nxt;
        if (w_load)   r_active <= w_load_val;
        if (w_wr_hit) r_shadow <= WrData;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_load      = 1'b1;
      case (r_state)
        S_IDLE: begin
          if (En[i]) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!En[i]) begin
            w_state_nxt = S_IDLE;
          end else if (!w_wrap) begin
            w_cnt_nxt = r_cnt + c_one;
            w_load    = 1'b0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    always_comb begin
      w_view_nxt = 1'b0;
      w_tick_nxt = 1'b0;
      if (En[i]) begin
        case (r_state)
          S_IDLE: w_view_nxt = 1'b1;
          S_RUN: begin
            if (w_wrap) begin
              w_view_nxt = 1'b1;
              w_tick_nxt = 1'b1;
            end else begin
              w_view_nxt = ((r_cnt + c_one) < w_half);
            end
          end
          default: w_view_nxt = 1'b0;
        endcase
      end
    end

    assign view[i] = r_view;
    assign tick[i] = r_tick;
  end

endmodule

`default_nettype wire
